fpu_cop1_responder: RTL and testbench

//  FPU-side end of the CPU<->COP1 interface: watches the CPU instruction stream, owns the 32x32 FPR file,

---
 rtl/fpu_pkg.sv | 75 +++++++
 rtl/fpu_cop1_if.sv | 28 ++
 rtl/fpu_cop1_responder_fpr.sv | 39 +++
 rtl/fpu_cop1_responder.sv | 113 +++++++++++
 tb/tb_fpu_cop1_responder.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fpu_pkg.sv
// fpu_pkg: COP1 opcode constants, instruction field slices and
// decode helpers shared by the FPU-side CPU interface.
package fpu_pkg;
  localparam int INST_W = 32;
  localparam int IDX_W  = 5;

  localparam logic [5:0] OP_COP1 = 6'h11;
  localparam logic [4:0] FMT_MF  = 5'h00;
  localparam logic [4:0] FMT_MT  = 5'h04;
  localparam logic [4:0] FMT_S   = 5'h10;

  localparam logic [5:0] FUNCT_ADD = 6'h00;
  localparam logic [5:0] FUNCT_SUB = 6'h01;
  localparam logic [5:0] FUNCT_MUL = 6'h02;
  localparam logic [5:0] FUNCT_DIV = 6'h03;

  localparam int OP_LSB  = 26;
  localparam int FMT_LSB = 21;
  localparam int FT_LSB  = 16;
  localparam int FS_LSB  = 11;
  localparam int FD_LSB  = 6;

  typedef logic [INST_W-1:0] inst_t;
  typedef logic [IDX_W-1:0]  idx_t;

  typedef struct packed {
    idx_t       fd;
    logic [5:0] funct;
  } op_t;

  function automatic logic [5:0] f_op(inst_t w);
    return w[OP_LSB +: 6];
  endfunction

  function automatic logic [4:0] f_fmt(inst_t w);
    return w[FMT_LSB +: 5];
  endfunction

  function automatic idx_t f_ft(inst_t w);
    return w[FT_LSB +: IDX_W];
  endfunction

  function automatic idx_t f_fs(inst_t w);
    return w[FS_LSB +: IDX_W];
  endfunction

  function automatic idx_t f_fd(inst_t w);
    return w[FD_LSB +: IDX_W];
  endfunction

  function automatic logic [5:0] f_funct(inst_t w);
    return w[5:0];
  endfunction

  function automatic logic is_mt(inst_t w);
    return f_op(w) == OP_COP1 && f_fmt(w) == FMT_MT &&
           w[FS_LSB-1:0] == 11'd0;
  endfunction

  function automatic logic is_mf(inst_t w);
    return f_op(w) == OP_COP1 && f_fmt(w) == FMT_MF &&
           w[FS_LSB-1:0] == 11'd0;
  endfunction

  function automatic logic is_arith(inst_t w);
    logic ok;
    ok = 1'b0;
    unique case (f_funct(w))
      FUNCT_ADD, FUNCT_SUB,
      FUNCT_MUL, FUNCT_DIV: ok = 1'b1;
      default:              ok = 1'b0;
    endcase
    return f_op(w) == OP_COP1 && f_fmt(w) == FMT_S && ok;
  endfunction
endpackage

// File: rtl/fpu_cop1_if.sv
// fpu_cop1_if: CPU<->COP1 transfer signals plus the start/done
// link to the FPU execution unit.
interface fpu_cop1_if #(
  parameter int DATA_W = 32
);
  import fpu_pkg::*;

  inst_t             inst;
  logic [DATA_W-1:0] GPR_out;
  logic [DATA_W-1:0] GPR_in;
  logic              hold;
  logic              ex_start;
  logic [5:0]        ex_funct;
  logic [DATA_W-1:0] ex_a;
  logic [DATA_W-1:0] ex_b;
  logic              ex_done;
  logic [DATA_W-1:0] ex_result;

  modport master (
    output inst, GPR_out, ex_done, ex_result,
    input  GPR_in, hold, ex_start, ex_funct, ex_a, ex_b
  );

  modport slave (
    input  inst, GPR_out, ex_done, ex_result,
    output GPR_in, hold, ex_start, ex_funct, ex_a, ex_b
  );
endinterface

// File: rtl/fpu_cop1_responder_fpr.sv
// fpu_fpr_file: floating-point register file, three combinational
// read ports and two write ports with the exec result on top.
module fpu_fpr_file
  import fpu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NREG   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  idx_t              ra_idx,
  input  idx_t              rb_idx,
  input  idx_t              rc_idx,
  output logic [DATA_W-1:0] ra_data,
  output logic [DATA_W-1:0] rb_data,
  output logic [DATA_W-1:0] rc_data,
  input  logic              we_mt,
  input  idx_t              wi_mt,
  input  logic [DATA_W-1:0] wd_mt,
  input  logic              we_ex,
  input  idx_t              wi_ex,
  input  logic [DATA_W-1:0] wd_ex
);
  logic [DATA_W-1:0] regs [NREG];

  assign ra_data = regs[ra_idx];
  assign rb_data = regs[rb_idx];
  assign rc_data = regs[rc_idx];

  // Exec write is issued last so it wins a same-index collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      if (we_mt) regs[wi_mt] <= wd_mt;
      if (we_ex) regs[wi_ex] <= wd_ex;
    end
  end
endmodule

// File: rtl/fpu_cop1_responder.sv
// fpu_cop1_responder: FPU end of the CPU<->COP1 link; MTC1/MFC1
// transfers at the CPU delay stage and dispatch of arithmetic.
module fpu_cop1_responder
  import fpu_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int NREG         = 32,
  parameter bit HAZARD_CHECK = 1'b1
) (
  input  logic      clk,
  input  logic      rst,
  fpu_cop1_if.slave bus
);
  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t state, state_n;
  inst_t  ff1, ff2;
  op_t    op_q;
  logic [DATA_W-1:0] a_q, b_q;
  logic [DATA_W-1:0] rd_fs, rd_ft, rd_mf;
  idx_t   i_fs, i_ft, p1_fs, p2_fs;
  logic   busy, arith, hit1, hit2;
  logic   interlock, issue, wr_ex;

  assign i_fs  = f_fs(bus.inst);
  assign i_ft  = f_ft(bus.inst);
  assign p1_fs = f_fs(ff1);
  assign p2_fs = f_fs(ff2);

  assign busy  = (state == S_BUSY);
  assign arith = is_arith(bus.inst);

  // An MTC1 still in the delay pipe would feed a stale operand.
  assign hit1 = is_mt(ff1) && (p1_fs == i_fs || p1_fs == i_ft);
  assign hit2 = is_mt(ff2) && (p2_fs == i_fs || p2_fs == i_ft);

  assign interlock = HAZARD_CHECK && arith && (hit1 || hit2);
  assign issue     = arith && !busy && !interlock;
  assign wr_ex     = busy && bus.ex_done;

  fpu_fpr_file #(
    .DATA_W(DATA_W),
    .NREG  (NREG)
  ) u_fpr (
    .clk    (clk),
    .rst    (rst),
    .ra_idx (i_fs),
    .rb_idx (i_ft),
    .rc_idx (p2_fs),
    .ra_data(rd_fs),
    .rb_data(rd_ft),
    .rc_data(rd_mf),
    .we_mt  (is_mt(ff2)),
    .wi_mt  (p2_fs),
    .wd_mt  (bus.GPR_out),
    .we_ex  (wr_ex),
    .wi_ex  (op_q.fd),
    .wd_ex  (bus.ex_result)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      ff1 <= '0;
      ff2 <= '0;
    end else begin
      ff1 <= bus.inst;
      ff2 <= ff1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: if (issue)       state_n = S_BUSY;
      S_BUSY: if (bus.ex_done) state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q <= '0;
      a_q  <= '0;
      b_q  <= '0;
    end else if (issue) begin
      op_q.fd    <= f_fd(bus.inst);
      op_q.funct <= f_funct(bus.inst);
      a_q        <= rd_fs;
      b_q        <= rd_ft;
    end
  end

  always_comb begin
    bus.hold     = 1'b0;
    bus.ex_start = 1'b0;
    bus.GPR_in   = '0;
    if (!rst) begin
      bus.hold = (arith && !busy) ||
                 (busy && !bus.ex_done) ||
                 interlock;
      bus.ex_start = issue;
      if (is_mf(ff2)) bus.GPR_in = rd_mf;
    end
  end

  assign bus.ex_funct = op_q.funct;
  assign bus.ex_a     = a_q;
  assign bus.ex_b     = b_q;
endmodule

// File: tb/tb_fpu_cop1_responder.sv
// tb_fpu_cop1_responder: CPU/exec-unit stand-in driving the COP1
// responder, checked against a per-cycle behavioural model.
module tb_fpu_cop1_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fpu_cop1_if #(.DATA_W(32)) bus();

  fpu_cop1_responder #(
    .DATA_W      (32),
    .NREG        (32),
    .HAZARD_CHECK(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  typedef struct {
    logic [31:0] word;
    int          exp_start;
    int          exp_hold;
  } vec_t;

  int checks = 0;
  int errors = 0;

  logic [31:0] mfpr [32];
  logic [31:0] p1, p2;
  bit          mbusy;
  logic [4:0]  mfd;
  logic [31:0] ma, mb;
  logic [5:0]  mfn;
  bit          hold_e;

  bit          pend;
  int          cnt;
  logic [31:0] pres;
  bit          rand_mode, rand_gpr, stray_en;
  int          ex_lat;
  logic [31:0] ex_res, gpr_val;
  logic [31:0] prog [$];

  int          hold_cnt, start_cnt, gin_nz_cnt;
  logic [31:0] gin_last, obs_a;

  function automatic logic [31:0] w_mt(logic [4:0] rt, logic [4:0] fs);
    return {6'h11, 5'h04, rt, fs, 11'd0};
  endfunction

  function automatic logic [31:0] w_mf(logic [4:0] rt, logic [4:0] fs);
    return {6'h11, 5'h00, rt, fs, 11'd0};
  endfunction

  function automatic logic [31:0] w_ar(logic [5:0] fn, logic [4:0] fd,
                                       logic [4:0] fs, logic [4:0] ft);
    return {6'h11, 5'h10, ft, fs, fd, fn};
  endfunction

  function automatic bit m_mt(logic [31:0] w);
    return w[31:26] == 6'h11 && w[25:21] == 5'h04 && w[10:0] == 11'd0;
  endfunction

  function automatic bit m_mf(logic [31:0] w);
    return w[31:26] == 6'h11 && w[25:21] == 5'h00 && w[10:0] == 11'd0;
  endfunction

  function automatic bit m_ar(logic [31:0] w);
    return w[31:26] == 6'h11 && w[25:21] == 5'h10 && w[5:0] < 6'd4;
  endfunction

  function automatic logic [31:0] gen();
    logic [4:0] a, b, c;
    a = 5'($urandom_range(7));
    b = 5'($urandom_range(7));
    c = 5'($urandom_range(7));
    case ($urandom_range(4))
      0, 1:    return w_mt(5'($urandom), a);
      2:       return w_mf(5'($urandom), a);
      3:       return w_ar(6'($urandom_range(3)), a, b, c);
      default: return $urandom;
    endcase
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Evaluate one cycle: compare DUT outputs, then advance the model.
  task automatic model_eval();
    logic [31:0] w, ge, na, nb;
    bit ar, il, he, se;
    w = bus.inst;
    if (rst) begin
      chk("rst_hold", 32'(bus.hold), 32'd0);
      chk("rst_start", 32'(bus.ex_start), 32'd0);
      chk("rst_gpr_in", bus.GPR_in, 32'd0);
      for (int i = 0; i < 32; i++) mfpr[i] = 32'd0;
      p1 = 32'd0;
      p2 = 32'd0;
      mbusy = 1'b0;
      hold_e = 1'b0;
      return;
    end
    ar = m_ar(w);
    il = ar && ((m_mt(p1) && (p1[15:11] == w[15:11] ||
                              p1[15:11] == w[20:16])) ||
                (m_mt(p2) && (p2[15:11] == w[15:11] ||
                              p2[15:11] == w[20:16])));
    he = (ar && !mbusy) || (mbusy && !bus.ex_done) || il;
    se = ar && !mbusy && !il;
    ge = m_mf(p2) ? mfpr[p2[15:11]] : 32'd0;
    chk("hold", 32'(bus.hold), 32'(he));
    chk("ex_start", 32'(bus.ex_start), 32'(se));
    chk("gpr_in", bus.GPR_in, ge);
    if (mbusy) begin
      chk("ex_a", bus.ex_a, ma);
      chk("ex_b", bus.ex_b, mb);
      chk("ex_funct", 32'(bus.ex_funct), 32'(mfn));
      obs_a = bus.ex_a;
    end
    hold_cnt += int'(bus.hold);
    start_cnt += int'(bus.ex_start);
    if (bus.GPR_in != 32'd0) begin
      gin_nz_cnt++;
      gin_last = bus.GPR_in;
    end
    na = mfpr[w[15:11]];
    nb = mfpr[w[20:16]];
    if (m_mt(p2)) mfpr[p2[15:11]] = bus.GPR_out;
    if (mbusy && bus.ex_done) begin
      mfpr[mfd] = bus.ex_result;
      mbusy = 1'b0;
    end else if (se) begin
      mbusy = 1'b1;
      mfd = w[10:6];
      mfn = w[5:0];
      ma = na;
      mb = nb;
      pend = 1'b1;
      cnt = rand_mode ? int'($urandom_range(5, 1)) : ex_lat;
      pres = rand_mode ? $urandom : ex_res;
    end
    p2 = p1;
    p1 = w;
    hold_e = he;
  endtask

  task automatic drive();
    if (!hold_e) begin
      if (prog.size() != 0) bus.inst = prog.pop_front();
      else if (rand_mode)   bus.inst = gen();
      else                  bus.inst = 32'd0;
    end
    bus.GPR_out = rand_gpr ? $urandom : gpr_val;
    bus.ex_done = 1'b0;
    bus.ex_result = $urandom;
    if (pend) begin
      cnt--;
      if (cnt == 0) begin
        bus.ex_done = 1'b1;
        bus.ex_result = pres;
        pend = 1'b0;
      end
    end else if (stray_en && $urandom_range(15) == 0) begin
      bus.ex_done = 1'b1;
    end
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      model_eval();
      @(posedge clk);
      #1;
      drive();
    end
  endtask

  vec_t tbl [10];

  initial begin
    tbl[0] = '{32'h3C01_1234, 0, 0};
    tbl[1] = '{32'h4620_1080, 0, 0};
    tbl[2] = '{w_ar(6'h00, 5'd1, 5'd2, 5'd3), 1, 2};
    tbl[3] = '{w_ar(6'h01, 5'd4, 5'd0, 5'd6), 1, 2};
    tbl[4] = '{w_ar(6'h02, 5'd9, 5'd8, 5'd8), 1, 2};
    tbl[5] = '{w_ar(6'h03, 5'd0, 5'd1, 5'd31), 1, 2};
    tbl[6] = '{w_ar(6'h04, 5'd1, 5'd2, 5'd3), 0, 0};
    tbl[7] = '{w_mt(5'd1, 5'd2) | 32'h1, 0, 0};
    tbl[8] = '{w_mf(5'd1, 5'd2), 0, 0};
    tbl[9] = '{w_ar(6'h3F, 5'd1, 5'd2, 5'd3), 0, 0};

    bus.inst = 32'd0;
    bus.GPR_out = 32'd0;
    bus.ex_done = 1'b0;
    bus.ex_result = 32'd0;
    pend = 1'b0; cnt = 0; pres = 32'd0;
    rand_mode = 1'b0; rand_gpr = 1'b0; stray_en = 1'b0;
    ex_lat = 2; ex_res = 32'd0; gpr_val = 32'd0;
    hold_cnt = 0; start_cnt = 0; gin_nz_cnt = 0;
    gin_last = 32'd0; obs_a = 32'd0;
    hold_e = 1'b0; mbusy = 1'b0;
    p1 = 32'd0; p2 = 32'd0;

    rst = 1'b1;
    run(2);
    rst = 1'b0;
    run(1);
    chk("reset_ex_a", bus.ex_a, 32'd0);
    chk("reset_ex_b", bus.ex_b, 32'd0);
    chk("reset_ex_funct", 32'(bus.ex_funct), 32'd0);

    // MTC1 then MFC1 round trip through FPR[3]
    gpr_val = 32'h3F80_0000;
    hold_cnt = 0;
    prog.push_back(w_mt(5'd2, 5'd3));
    run(5);
    chk("t1_hold", 32'(hold_cnt), 32'd0);
    gin_nz_cnt = 0;
    prog.push_back(w_mf(5'd1, 5'd3));
    run(5);
    chk("t2_gin_cycles", 32'(gin_nz_cnt), 32'd1);
    chk("t2_gin_val", gin_last, 32'h3F80_0000);

    // ADD.S fd=5 fs=3 ft=3, exec takes 4 cycles
    ex_lat = 4;
    ex_res = 32'h4000_0000;
    hold_cnt = 0; start_cnt = 0;
    prog.push_back(w_ar(6'h00, 5'd5, 5'd3, 5'd3));
    run(10);
    chk("t3_starts", 32'(start_cnt), 32'd1);
    chk("t3_hold", 32'(hold_cnt), 32'd4);
    chk("t3_ex_a", obs_a, 32'h3F80_0000);
    gin_nz_cnt = 0;
    prog.push_back(w_mf(5'd1, 5'd5));
    run(5);
    chk("t3_fpr5", gin_last, 32'h4000_0000);

    // MTC1 fs=7 immediately followed by a consumer of FPR[7]
    gpr_val = 32'h4040_0000;
    ex_lat = 3;
    ex_res = 32'h1234_5678;
    hold_cnt = 0; start_cnt = 0;
    prog.push_back(w_mt(5'd0, 5'd7));
    prog.push_back(w_ar(6'h00, 5'd2, 5'd7, 5'd1));
    run(12);
    chk("t4_starts", 32'(start_cnt), 32'd1);
    chk("t4_hold", 32'(hold_cnt), 32'd5);
    chk("t4_ex_a", obs_a, 32'h4040_0000);

    // reset two cycles into a 6-cycle op; late done must be dropped
    ex_lat = 6;
    ex_res = 32'hDEAD_BEEF;
    start_cnt = 0;
    prog.push_back(w_ar(6'h01, 5'd6, 5'd3, 5'd5));
    run(3);
    chk("t5_launched", 32'(start_cnt), 32'd1);
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    hold_cnt = 0; start_cnt = 0;
    run(8);
    chk("t5_hold", 32'(hold_cnt), 32'd0);
    chk("t5_starts", 32'(start_cnt), 32'd0);
    gin_nz_cnt = 0;
    prog.push_back(w_mf(5'd1, 5'd6));
    prog.push_back(w_mf(5'd1, 5'd3));
    run(6);
    chk("t5_fpr_clear", 32'(gin_nz_cnt), 32'd0);

    // decode table, each word applied on an idle pipe
    ex_lat = 2;
    ex_res = 32'h0BAD_F00D;
    for (int i = 0; i < 10; i++) begin
      hold_cnt = 0; start_cnt = 0;
      prog.push_back(tbl[i].word);
      run(6);
      chk($sformatf("tbl%0d_start", i), 32'(start_cnt),
          32'(tbl[i].exp_start));
      chk($sformatf("tbl%0d_hold", i), 32'(hold_cnt),
          32'(tbl[i].exp_hold));
    end

    // random instruction mix with random exec latency and stray dones
    rand_mode = 1'b1;
    rand_gpr = 1'b1;
    stray_en = 1'b1;
    run(600);
    rand_mode = 1'b0;
    stray_en = 1'b0;
    run(12);
    for (int i = 0; i < 32; i++) prog.push_back(w_mf(5'd1, 5'(i)));
    run(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
